// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, line levels, default divisor and
// the LCD/ASCII byte constants used by both the screen transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int CLKS_PER_BIT_DEFAULT = 5208;

  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME   = 8'h02;
  localparam logic [7:0] LCD_CMD_ON     = 8'h0C;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;

  // XOR of all data bits; a matching even-parity bit makes the frame total 0.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts while clr is low and flags the half-bit and
// full-bit points; wraps to zero on the full-bit tick.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] FULL_LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_s;

  assign half_tick = (cnt_r == HALF_LAST);
  assign full_tick = (cnt_r == FULL_LAST);

  // Next divider value: cleared on request or at the end of a bit period.
  always_comb begin
    cnt_s = cnt_r;
    if (clr || full_tick) begin
      cnt_s = {W{1'b0}};
    end else begin
      cnt_s = cnt_r + W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver with one-entry holding register and valid/ready handshake.
// Define RX_PARITY_EN to add an even parity bit between data bit 7 and stop.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inSerial,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       frameErr,
  output logic       overrun,
  output logic       parityErr
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  rx_state_e              state_r, state_s;
  logic [2:0]             bit_idx_r, bit_idx_s;
  logic [7:0]             shift_r, shift_s;
  logic [7:0]             data_s;
  logic                   valid_s, frame_err_s, overrun_s, parity_err_s;
  logic                   parity_ok_s;
  logic                   half_tick_s, full_tick_s, clr_s;

  assign rx_s  = sync_r[SYNC_STAGES-1];
  assign clr_s = (state_r == IDLE) || (state_r == BREAK) ||
                 ((state_r == START) && half_tick_s);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr_s),
    .half_tick (half_tick_s),
    .full_tick (full_tick_s)
  );

`ifdef RX_PARITY_EN
  logic par_bit_r, par_bit_s;
  assign parity_ok_s = ~(even_parity(shift_r) ^ par_bit_r);
`else
  assign parity_ok_s = 1'b1;
`endif

  // Frame FSM next state, byte assembly, delivery and error pulses.
  always_comb begin
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    data_s       = rxData;
    frame_err_s  = 1'b0;
    overrun_s    = 1'b0;
    parity_err_s = 1'b0;
`ifdef RX_PARITY_EN
    par_bit_s    = par_bit_r;
`endif
    if (rxValid && rxReady) begin
      valid_s = 1'b0;
    end else begin
      valid_s = rxValid;
    end
    case (state_r)
      IDLE: begin
        if (rx_s == START_BIT) state_s = START;
        else                   state_s = IDLE;
      end
      START: begin
        if (half_tick_s) begin
          // A start bit gone high by mid-bit was only a glitch.
          if (rx_s == START_BIT) begin
            state_s   = DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s   = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (full_tick_s) begin
          shift_s[bit_idx_r] = rx_s;
          bit_idx_s          = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef RX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (full_tick_s) begin
          par_bit_s = rx_s;
          state_s   = STOP;
        end else begin
          state_s   = PARITY;
        end
      end
`endif
      STOP: begin
        if (full_tick_s) begin
          parity_err_s = ~parity_ok_s;
          if (rx_s == STOP_BIT) begin
            state_s = IDLE;
            if (!parity_ok_s) begin
              data_s = rxData;
            end else if (!rxValid || rxReady) begin
              data_s  = shift_r;
              valid_s = 1'b1;
            end else begin
              overrun_s = 1'b1;
            end
          end else begin
            frame_err_s = 1'b1;
            state_s     = BREAK;
          end
        end else begin
          state_s = STOP;
        end
      end
      BREAK: begin
        if (rx_s == STOP_BIT) state_s = IDLE;
        else                  state_s = BREAK;
      end
      default: state_s = IDLE;
    endcase
  end

  // Input synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r    <= {SYNC_STAGES{1'b1}};
      state_r   <= IDLE;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      rxData    <= 8'h00;
      rxValid   <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
      parityErr <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], inSerial};
      state_r   <= state_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      rxData    <= data_s;
      rxValid   <= valid_s;
      frameErr  <= frame_err_s;
      overrun   <= overrun_s;
      parityErr <= parity_err_s;
`ifdef RX_PARITY_EN
      par_bit_r <= par_bit_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module at CLKS_PER_BIT=16: table of frames plus
// hand sequences for glitch, framing error, overrun, mid-frame reset, parity.
module tb_uart_rx_module;

  localparam int CPB = 16;
  // falling edge -> rxValid: 2 sync + 1 IDLE + (HALF-1) + stop sample * CPB + 1
`ifdef RX_PARITY_EN
  localparam int LAT = 2 + 1 + 7 + 10 * CPB + 1;
`else
  localparam int LAT = 2 + 1 + 7 + 9 * CPB + 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       inSerial = 1'b1;
  logic       rxReady = 1'b1;
  logic [7:0] rxData;
  logic       rxValid, frameErr, overrun, parityErr;

  uart_rx_module #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .inSerial  (inSerial),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxReady   (rxReady),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .parityErr (parityErr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int high_cnt, ferr_cnt, ovr_cnt, perr_cnt;
  logic prev_valid = 1'b0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rxValid && !prev_valid) begin
      rx_q.push_back(rxData);
      rise_cyc = cyc_cnt;
    end
    if (rxValid)   high_cnt++;
    if (frameErr)  ferr_cnt++;
    if (overrun)   ovr_cnt++;
    if (parityErr) perr_cnt++;
    prev_valid = rxValid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    high_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0;
    rx_q.delete();
  endtask

  // Leaves the line at the stop-bit level when it returns.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    inSerial = 1'b0;
    fall_cyc = cyc_cnt;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      inSerial = d[i];
      tick(CPB);
    end
`ifdef RX_PARITY_EN
    inSerial = par;
    tick(CPB);
`else
    if (par) inSerial = 1'b1;
`endif
    inSerial = stop;
    tick(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'hA5, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b0, 0, 1};
    vecs[5] = '{8'h01, 1'b1, 1, 0};

    clear_mon();
    tick(3);
    chk("reset_rxData", rxData, 8'h00);
    chk("reset_rxValid", rxValid, 1'b0);
    chk("reset_flags", {frameErr, overrun, parityErr}, 3'b000);
    reset_n = 1'b1;
    tick(5);

    // Basic frame, latency and single-cycle valid.
    clear_mon();
    send_frame(8'h53, 1'b1, 1'b0);
    tick(20);
    chk("b53_count", rx_q.size(), 1);
    chk("b53_data", rx_q[0], 8'h53);
    chk("b53_latency", rise_cyc - fall_cyc, LAT);
    chk("b53_valid_cycles", high_cnt, 1);
    chk("b53_flags", ferr_cnt + ovr_cnt + perr_cnt, 0);

    // Short low glitch.
    clear_mon();
    inSerial = 1'b0;
    tick(4);
    inSerial = 1'b1;
    tick(40);
    chk("glitch_valid", high_cnt, 0);
    chk("glitch_ferr", ferr_cnt, 0);
    chk("glitch_ovr", ovr_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
      inSerial = 1'b1;
      tick(20);
      chk($sformatf("vec%0d_count", i), rx_q.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0) chk($sformatf("vec%0d_data", i), rx_q[0], vecs[i].data);
      chk($sformatf("vec%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovr", i), ovr_cnt, 0);
      chk($sformatf("vec%0d_perr", i), perr_cnt, 0);
      chk($sformatf("vec%0d_vcyc", i), high_cnt, vecs[i].exp_n);
    end

    // Back-to-back frames with no idle time.
    clear_mon();
    send_frame(8'hC3, 1'b1, ^8'hC3);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    tick(20);
    chk("b2b_count", rx_q.size(), 2);
    chk("b2b_data0", rx_q[0], 8'hC3);
    chk("b2b_data1", rx_q[1], 8'h3C);

    // Framing error followed by a held-low line, then a good frame.
    clear_mon();
    send_frame(8'hFE, 1'b0, ^8'hFE);
    tick(40);
    chk("fe_ferr", ferr_cnt, 1);
    chk("fe_no_valid", high_cnt, 0);
    inSerial = 1'b1;
    tick(16);
    send_frame(8'h01, 1'b1, ^8'h01);
    tick(20);
    chk("fe_next_count", rx_q.size(), 1);
    chk("fe_next_data", rx_q[0], 8'h01);
    chk("fe_ferr_total", ferr_cnt, 1);

    // Overrun with consumer stalled.
    clear_mon();
    rxReady = 1'b0;
    send_frame(8'h41, 1'b1, ^8'h41);
    tick(10);
    send_frame(8'h4C, 1'b1, ^8'h4C);
    tick(20);
    chk("ovr_data", rxData, 8'h41);
    chk("ovr_valid", rxValid, 1'b1);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_count", rx_q.size(), 1);
    rxReady = 1'b1;
    tick(1);
    chk("ovr_consumed", rxValid, 1'b0);

    // Reset during data bit 4.
    clear_mon();
    inSerial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      inSerial = 8'h3A >> i;
      tick(CPB);
    end
    inSerial = 1'b1;
    tick(8);
    reset_n = 1'b0;
    #1;
    chk("rst_rxData", rxData, 8'h00);
    chk("rst_rxValid", rxValid, 1'b0);
    chk("rst_flags", {frameErr, overrun, parityErr}, 3'b000);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    clear_mon();
    send_frame(8'h3A, 1'b1, ^8'h3A);
    tick(20);
    chk("rst_next_count", rx_q.size(), 1);
    chk("rst_next_data", rx_q[0], 8'h3A);
    chk("rst_next_flags", ferr_cnt + ovr_cnt + perr_cnt, 0);

`ifdef RX_PARITY_EN
    clear_mon();
    send_frame(8'h31, 1'b1, 1'b0);
    tick(20);
    chk("par_bad_perr", perr_cnt, 1);
    chk("par_bad_count", rx_q.size(), 0);
    clear_mon();
    send_frame(8'h31, 1'b1, 1'b1);
    tick(20);
    chk("par_good_perr", perr_cnt, 0);
    chk("par_good_count", rx_q.size(), 1);
    chk("par_good_data", rx_q[0], 8'h31);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
